ctrl: RTL and testbench

CTRL -- requirements
Module: ctrl

---
 rtl/ctrl.sv | 105 ++++++++++
 tb/tb_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ctrl
// Purpose  : Pipeline hazard controller. Produces per-stage stall vector,
//            flushes the front end on taken jumps and redirects the PC,
//            deferring the redirect while an instruction fetch is in flight.
//            Also counts cycles in which the PC is stalled.
// Ports    : clk_i, rst_i             - clock, synchronous active-high reset
//            stallreq_{if,id,ex,mem}_i - stall requests from each stage
//            jump_req_i, jump_addr_i  - taken jump resolved in EX
//            stall_o[5:0]             - per-stage stall (0 PC .. 5 WB), 1=STOP
//            flush_jump_o             - flush IF/ID and ID/EX
//            redirect_o, redirect_addr_o - PC load strobe and target
//            stall_cycles_o           - free-running PC-stall cycle count
// Revision : 1.0 - initial release
// ============================================================================
module ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stallreq_if_i,
  input  logic                  stallreq_id_i,
  input  logic                  stallreq_ex_i,
  input  logic                  stallreq_mem_i,
  input  logic                  jump_req_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  output logic [5:0]            stall_o,
  output logic                  flush_jump_o,
  output logic                  redirect_o,
  output logic [ADDR_WIDTH-1:0] redirect_addr_o,
  output logic [31:0]           stall_cycles_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pend_addr;
  logic [31:0]           r_stall_cycles;

  logic w_back_stall;   // EX or MEM busy: the jump cannot complete yet
  logic w_accept;
  logic w_accept_now;
  logic w_pend_release;
  logic w_flush;
  logic [5:0] w_stall;

  assign w_back_stall   = stallreq_ex_i | stallreq_mem_i;
  assign w_accept       = ~rst_i & (r_state == ST_IDLE) & jump_req_i & ~w_back_stall;
  assign w_accept_now   = w_accept & ~stallreq_if_i;
  assign w_pend_release = ~rst_i & (r_state == ST_PEND) & ~stallreq_if_i & ~w_back_stall;
  assign w_flush        = ~rst_i & (w_accept | (r_state == ST_PEND));

  // The load-use bubble is dropped while flushing: the instructions it would
  // protect are being discarded anyway, and keeping it would stall the PC in
  // the very cycle the redirect must load it.
  always_comb begin
    w_stall = 6'b000000;
    if (!rst_i) begin
      if (stallreq_mem_i)                 w_stall = 6'b011111;
      else if (stallreq_ex_i)             w_stall = 6'b001111;
      else if (stallreq_id_i && !w_flush) w_stall = 6'b000111;
      else if (stallreq_if_i)             w_stall = 6'b000011;
    end
  end

  assign stall_o        = w_stall;
  assign flush_jump_o   = w_flush;
  assign redirect_o     = w_accept_now | w_pend_release;
  assign stall_cycles_o = r_stall_cycles;

  always_comb begin
    redirect_addr_o = '0;
    if (w_accept_now)        redirect_addr_o = jump_addr_i;
    else if (w_pend_release) redirect_addr_o = r_pend_addr;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= ST_IDLE;
      r_pend_addr    <= '0;
      r_stall_cycles <= 32'd0;
    end else begin
      if (w_stall[0]) r_stall_cycles <= r_stall_cycles + 32'd1;
      case (r_state)
        ST_IDLE: begin
          // Fetch still busy: hold the target until the in-flight fetch retires.
          if (w_accept && stallreq_if_i) begin
            r_pend_addr <= jump_addr_i;
            r_state     <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (w_pend_release) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl
// Purpose  : Self-checking bench for ctrl. Directed scenarios plus random
//            stimulus, compared cycle by cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl;
  localparam int AW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          sif, sid, sex, smem, jr;
  logic [AW-1:0] jaddr;
  logic [5:0]    stall_o;
  logic          flush_jump_o, redirect_o;
  logic [AW-1:0] redirect_addr_o;
  logic [31:0]   stall_cycles_o;

  ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .stallreq_if_i  (sif),
    .stallreq_id_i  (sid),
    .stallreq_ex_i  (sex),
    .stallreq_mem_i (smem),
    .jump_req_i     (jr),
    .jump_addr_i    (jaddr),
    .stall_o        (stall_o),
    .flush_jump_o   (flush_jump_o),
    .redirect_o     (redirect_o),
    .redirect_addr_o(redirect_addr_o),
    .stall_cycles_o (stall_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: a jump "owed" to the PC plus a stall-cycle tally.
  bit          m_owed;
  logic [AW-1:0] m_owed_addr;
  longint      m_cnt;

  // Observed outputs of the last cycle, for directed checks.
  logic [5:0]    o_stall;
  logic          o_flush, o_redir;
  logic [AW-1:0] o_addr;

  task automatic cycle(input bit r, input bit f_if, input bit f_id, input bit f_ex,
                       input bit f_mem, input bit j, input logic [AW-1:0] a);
    int          depth;
    bit          can_take, e_flush, e_redir;
    logic [5:0]  e_stall;
    logic [AW-1:0] e_addr;
    @(negedge clk_i);
    rst_i = r; sif = f_if; sid = f_id; sex = f_ex; smem = f_mem; jr = j; jaddr = a;
    #1;
    // Jump completes only when nothing behind EX is holding it.
    can_take = !r && !m_owed && j && !f_ex && !f_mem;
    e_flush  = !r && (m_owed || can_take);
    // Number of leading stages frozen by the oldest stalled stage.
    depth = 0;
    if (!r) begin
      if (f_mem)                depth = 5;
      else if (f_ex)            depth = 4;
      else if (f_id && !e_flush) depth = 3;
      else if (f_if)            depth = 2;
    end
    e_stall = 6'((1 << depth) - 1);
    e_redir = 1'b0;
    e_addr  = '0;
    if (can_take && !f_if) begin
      e_redir = 1'b1; e_addr = a;
    end else if (!r && m_owed && !f_if && !f_ex && !f_mem) begin
      e_redir = 1'b1; e_addr = m_owed_addr;
    end
    o_stall = stall_o; o_flush = flush_jump_o; o_redir = redirect_o; o_addr = redirect_addr_o;
    check("stall",    64'(stall_o),         64'(e_stall));
    check("flush",    64'(flush_jump_o),    64'(e_flush));
    check("redirect", 64'(redirect_o),      64'(e_redir));
    check("raddr",    64'(redirect_addr_o), 64'(e_addr));
    check("count",    64'(stall_cycles_o),  64'(m_cnt[31:0]));
    @(posedge clk_i);
    if (r) begin
      m_owed = 0; m_owed_addr = '0; m_cnt = 0;
    end else begin
      if (e_stall[0]) m_cnt = (m_cnt + 1) % 64'h1_0000_0000;
      if (can_take && f_if) begin
        m_owed = 1; m_owed_addr = a;
      end else if (m_owed && e_redir) begin
        m_owed = 0;
      end
    end
  endtask

  initial begin
    m_owed = 0; m_owed_addr = '0; m_cnt = 0;
    rst_i = 1; sif = 0; sid = 0; sex = 0; smem = 0; jr = 0; jaddr = '0;

    // Reset holds outputs quiet whatever the other inputs do.
    cycle(1, 1, 1, 1, 1, 1, 32'h1234);
    cycle(1, 0, 0, 0, 0, 1, 32'h40);
    check("rst_stall", 64'(o_stall), 64'd0);
    check("rst_redir", 64'(o_redir), 64'd0);

    // mem + if together: full front stall, counter advances.
    cycle(0, 1, 0, 0, 1, 0, 0);
    check("memif_stall", 64'(o_stall), 64'h1F);
    cycle(0, 1, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("memif_count", 64'(stall_cycles_o), 64'd2);

    // Immediate jump.
    cycle(0, 0, 0, 0, 0, 1, 32'h100);
    check("jmp_flush", 64'(o_flush), 64'd1);
    check("jmp_addr",  64'(o_addr),  64'h100);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("jmp_after", 64'({o_flush, o_redir}), 64'd0);

    // Jump held off by EX busy for three cycles.
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, 0, 1, 32'h180);
      check("exhold_flush", 64'(o_flush), 64'd0);
    end
    cycle(0, 0, 0, 0, 0, 1, 32'h180);
    check("exrel_redir", 64'(o_redir), 64'd1);

    // Jump while fetch busy; second jump during PEND ignored.
    cycle(0, 1, 0, 0, 0, 1, 32'h200);
    check("pend_redir0", 64'(o_redir), 64'd0);
    cycle(0, 1, 0, 0, 0, 1, 32'h300);
    cycle(0, 1, 0, 0, 0, 1, 32'h300);
    check("pend_flush", 64'(o_flush), 64'd1);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("pend_addr", 64'(o_addr), 64'h200);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("pend_done", 64'(o_flush), 64'd0);

    // ID hazard does not block a jump.
    cycle(0, 0, 1, 0, 0, 1, 32'h440);
    check("id_jump", 64'(o_addr), 64'h440);

    // Reset during PEND discards the jump.
    cycle(0, 1, 0, 0, 0, 1, 32'h500);
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("rstpend_redir", 64'(o_redir), 64'd0);

    // Counter wrap.
    cycle(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    force dut.r_stall_cycles = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cycles;
    m_cnt = 64'hFFFF_FFFE;
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("wrap", 64'(stall_cycles_o), 64'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 39) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 2) == 0), AW'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
